// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among 4 requesters
module fifo_wr_arbiter #(
    parameter int FIFO_WIDTH = 16,
    parameter int BURST_LEN  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            req,
    input  logic [FIFO_WIDTH-1:0] data0,
    input  logic [FIFO_WIDTH-1:0] data1,
    input  logic [FIFO_WIDTH-1:0] data2,
    input  logic [FIFO_WIDTH-1:0] data3,
    input  logic                  full,
    output logic [3:0]            ack,
    output logic [FIFO_WIDTH-1:0] fifo_din,
    output logic                  fifo_wen,
    output logic                  busy,
    output logic [1:0]            cur_id
);
    localparam int CW = $clog2(BURST_LEN) + 1;
    logic [3:0]    gnt, gnt_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    last, last_nxt;
    logic          rel;

    // first set bit of r scanning s, s+1, ... (mod 4); zero when nothing requests
    function automatic logic [3:0] pick(input logic [3:0] r, input logic [1:0] s);
        logic [3:0] o;
        logic [1:0] k;
        o = '0;
        for (int i = 3; i >= 0; i--) begin
            k = s + 2'(i);
            if (r[k]) o = 4'b0001 << k;
        end
        return o;
    endfunction

    assign ack      = gnt & req & {4{~full & ~rst}};
    assign fifo_wen = |ack;
    assign busy     = |gnt;
    assign cur_id   = {gnt[3] | gnt[2], gnt[3] | gnt[1]};
    assign fifo_din = ({FIFO_WIDTH{gnt[0]}} & data0) | ({FIFO_WIDTH{gnt[1]}} & data1)
                    | ({FIFO_WIDTH{gnt[2]}} & data2) | ({FIFO_WIDTH{gnt[3]}} & data3);
    assign rel      = busy & ((ack[cur_id] & (cnt == CW'(BURST_LEN - 1))) | ~req[cur_id]);

    always_comb begin
        gnt_nxt  = gnt;
        cnt_nxt  = cnt;
        last_nxt = last;
        if (!busy) begin
            gnt_nxt = pick(req, last + 2'd1);
            cnt_nxt = '0;
        end else if (rel) begin
            gnt_nxt  = pick(req, cur_id + 2'd1);
            cnt_nxt  = '0;
            last_nxt = cur_id;
        end else if (ack[cur_id]) begin
            cnt_nxt = cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt  <= '0;
            cnt  <= '0;
            last <= 2'd3;
        end else begin
            gnt  <= gnt_nxt;
            cnt  <= cnt_nxt;
            last <= last_nxt;
        end
    end
endmodule
